// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with registered single-cycle ops and iterative shift-add MUL / restoring DIVU
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st, st_n;
  logic [3:0] op;
  logic [SW:0] cnt;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH:0] sum, dif, madd, shd, trial;
  logic [WIDTH-1:0] r, hi_n, lo_n;
  logic [SW-1:0] sh;
  logic c, v, is_long, is_mul, ge;
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign is_long = alu_op == 4'd8 || alu_op == 4'd9;
  assign is_mul = op == 4'd8;
  assign sh = in2[SW-1:0];
  always_comb begin
    sum = {1'b0, in1} + {1'b0, in2};
    dif = {1'b0, in1} - {1'b0, in2};
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_op)
      4'd0: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (in1[WIDTH-1] == in2[WIDTH-1]) && (r[WIDTH-1] != in1[WIDTH-1]);
      end
      4'd1: begin
        r = dif[WIDTH-1:0];
        c = dif[WIDTH];
        v = (in1[WIDTH-1] != in2[WIDTH-1]) && (r[WIDTH-1] != in1[WIDTH-1]);
      end
      4'd2: r = in1 & in2;
      4'd3: r = in1 | in2;
      4'd4: r = in1 ^ in2;
      4'd5: r = in1 << sh;
      4'd6: r = in1 >> sh;
      4'd7: r = $signed(in1) >>> sh;
      default: r = '0;
    endcase
  end
  // one iteration: MUL shifts the product right, DIVU shifts the quotient in from the right
  always_comb begin
    madd = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shd = {hi, lo[WIDTH-1]};
    trial = shd - {1'b0, m};
    ge = !trial[WIDTH];
    hi_n = is_mul ? madd[WIDTH:1] : (ge ? trial[WIDTH-1:0] : shd[WIDTH-1:0]);
    lo_n = is_mul ? {madd[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
  end
  always_comb begin
    st_n = st;
    case (st)
      IDLE: st_n = in_valid ? (is_long ? BUSY : DONE) : IDLE;
      BUSY: st_n = cnt == 1 ? DONE : BUSY;
      DONE: st_n = out_ready ? IDLE : DONE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      op <= '0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      out <= '0;
      out_hi <= '0;
      flags <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && in_valid) begin
        op <= alu_op;
        cnt <= (SW+1)'(WIDTH);
        hi <= '0;
        lo <= alu_op == 4'd8 ? in2 : in1;
        m <= alu_op == 4'd8 ? in1 : in2;
        if (!is_long) begin
          out <= r;
          out_hi <= '0;
          flags <= {r == '0, r[WIDTH-1], c, v};
        end
      end
      if (st == BUSY) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt - 1'b1;
        if (cnt == 1) begin
          out <= lo_n;
          out_hi <= hi_n;
          flags <= {lo_n == '0, lo_n[WIDTH-1], is_mul && hi_n != '0, is_mul ? hi_n != '0 : m == '0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed boundary cases plus random ops against an arithmetic reference model
module tb_alu_mc;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [7:0] in1 = 0, in2 = 0, out, out_hi;
  logic [3:0] alu_op = 0, flags;
  int checks = 0, errors = 0;
  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_hi(out_hi), .flags(flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic int sx(input int x);
    return x >= 128 ? x - 256 : x;
  endfunction
  // returns {flags, hi, lo}
  function automatic int model(input int op, input int a, input int b);
    int lo, hi, c, v, t, k;
    lo = 0; hi = 0; c = 0; v = 0; k = b % 8;
    case (op)
      0: begin t = a + b; lo = t % 256; c = t > 255; t = sx(a) + sx(b); v = t > 127 || t < -128; end
      1: begin lo = (a - b + 256) % 256; c = a < b; t = sx(a) - sx(b); v = t > 127 || t < -128; end
      2: lo = a & b;
      3: lo = a | b;
      4: lo = a ^ b;
      5: lo = (a << k) % 256;
      6: lo = a >> k;
      7: lo = (sx(a) >>> k) & 255;
      8: begin t = a * b; lo = t % 256; hi = t / 256; c = hi != 0; v = c; end
      9: if (b == 0) begin lo = 255; hi = a; v = 1; end else begin lo = a / b; hi = a % b; end
      default: ;
    endcase
    return ((lo == 0) << 19) | ((lo >= 128) << 18) | (c << 17) | (v << 16) | (hi << 8) | lo;
  endfunction
  task automatic run(input int op, input int a, input int b, input int hold);
    int e, lat;
    e = model(op, a, b);
    chk("idle_rdy", in_ready, 1);
    in_valid = 1; alu_op = op[3:0]; in1 = a[7:0]; in2 = b[7:0]; out_ready = 0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin
        in_valid = 1'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); alu_op = 4'($urandom);
      end
      if (!out_valid) chk("busy_rdy", in_ready, 0);
    end while (!out_valid && lat < 40);
    chk("latency", lat, (op == 8 || op == 9) ? 9 : 1);
    chk("out", out, e & 255);
    chk("out_hi", out_hi, (e >> 8) & 255);
    chk("flags", flags, (e >> 16) & 15);
    repeat (hold) begin
      in_valid = 1'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); alu_op = 4'($urandom);
      @(posedge clk); #1;
      chk("hold_out", out, e & 255);
      chk("hold_hi", out_hi, (e >> 8) & 255);
      chk("hold_flags", flags, (e >> 16) & 15);
      chk("hold_vld", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("ret_rdy", in_ready, 1);
    chk("ret_vld", out_valid, 0);
  endtask
  initial begin
    int op, a, b;
    in_valid = 1; alu_op = 0; in1 = 8'h0A; in2 = 8'h05;
    repeat (2) @(posedge clk);
    #1; rst = 0; in_valid = 0;
    chk("rst_out", out, 0);
    chk("rst_hi", out_hi, 0);
    chk("rst_flags", flags, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    @(posedge clk); #1;
    chk("rst_noacc", out_valid, 0);
    run(0, 8'h0A, 8'h05, 0);
    run(0, 8'hFF, 8'h01, 0);
    run(1, 8'h80, 8'h01, 1);
    run(1, 8'h01, 8'h02, 0);
    run(7, 8'h80, 8'h0B, 0);
    run(8, 8'h10, 8'h10, 0);
    run(9, 8'h64, 8'h07, 0);
    run(9, 8'h5A, 8'h00, 0);
    run(8, 8'hFF, 8'hFF, 5);
    run(12, 8'h33, 8'h44, 0);
    run(8, 8'hC3, 8'h7D, 0);
    in_valid = 1; alu_op = 8; in1 = 8'h0F; in2 = 8'h0E;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_out", out, 0);
    chk("mrst_hi", out_hi, 0);
    chk("mrst_flags", flags, 0);
    chk("mrst_rdy", in_ready, 1);
    run(0, 8'h21, 8'h12, 0);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      run(op, a, b, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, handshaked, multi-cycle successor to the combinational `alu`.
- Single-cycle ops (ADD/SUB/logic/shifts) are registered.
- MUL (shift-add) and DIVU (restoring) are iterative, one bit per cycle.
- Sits between the decode/issue stage and writeback. Valid/ready on both sides lets the core stall on long ops.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, ≥4; shift amount is in2[$clog2(WIDTH)-1:0]

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept; high only in IDLE
in1  input  WIDTH  operand A / dividend / multiplicand
in2  input  WIDTH  operand B / divisor / multiplier / shift amount
alu_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (unsigned), 9 DIVU; 10-15 reserved
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result / product low half / quotient
out_hi  output  WIDTH  product high half / remainder; 0 for single-cycle ops
flags  output  4  {zero, negative, carry, overflow}, bit3..bit0

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; out, out_hi, flags=0; out_valid=0; internal accumulators cleared.
  - Any op in flight is abandoned, no result is emitted, and in_valid is ignored that cycle.
- Reset applies from any state, including mid-MUL/DIVU.
- States: IDLE, BUSY, DONE.
- Input handshake: accept when in_valid && in_ready. Operands and op are latched, so inputs may change after acceptance.
- IDLE, accept, single-cycle or reserved op:
  - Result, out_hi and flags registered that edge; go to DONE.
  - out_valid is high the next cycle, i.e. latency 1.
- IDLE, accept, MUL/DIVU:
  - Go to BUSY and load counter = WIDTH.
  - Each BUSY cycle performs one iteration and decrements the counter.
  - When the counter reaches 0, the final result is registered and the block goes to DONE.
  - out_valid is first high WIDTH+1 cycles after the accept edge.
- DONE:
  - out_valid=1; in_ready=0.
  - out, out_hi and flags are held stable until out_ready=1, after which the block returns to IDLE.
  - No new accept can occur in the same cycle as the output handshake.
  - Maximum throughput: one single-cycle op per 2 cycles.
- BUSY: in_ready=0; out_valid=0; outputs hold their previous values.
- Arithmetic:
  - ADD: out = in1+in2 mod 2^WIDTH; carry = carry-out; overflow = signed overflow.
  - SUB: out = in1-in2 mod 2^WIDTH; carry = borrow (in1<in2 unsigned); overflow = signed overflow.
  - AND/OR/XOR: bitwise; carry=0; overflow=0.
  - SLL/SRL: logical shift; SRA: arithmetic shift (sign-fill).
    - Shift amount uses the low $clog2(WIDTH) bits of in2; upper bits are ignored.
    - carry=0, overflow=0.
  - MUL: full 2·WIDTH-bit unsigned product; {out_hi,out} = in1*in2; carry = overflow = (out_hi != 0).
  - DIVU: out = quotient, out_hi = remainder; carry=0.
    - Divisor 0: still takes WIDTH cycles; out = all-ones, out_hi = in1, overflow=1.
  - Reserved ops: out=0, out_hi=0; single-cycle.
- Flag derivation for every op, including reserved ones:
  - zero = (out == 0); out_hi is ignored.
  - negative = out[WIDTH-1].
- Flags are registered together with out and always correspond to the currently presented result.
- X-free: all outputs are defined at all times after the first reset.

Test Plan:
- WIDTH=8: ADD 0x0A+0x05, out_ready=1 -> out_valid 1 cycle after accept; out=0x0F, flags=0000; in_ready high again the cycle after the output handshake.
- Boundary arithmetic, WIDTH=8:
  - ADD 0xFF+0x01 -> out=0x00, flags=1010.
  - SUB 0x80-0x01 -> out=0x7F, flags=0001.
  - SUB 0x01-0x02 -> out=0xFF, flags=0110.
  - SRA 0x80 by in2=0x0B (uses 3) -> out=0xF0, flags=0100.
- MUL 0x10*0x10 -> in_ready low during BUSY; out_valid exactly 9 cycles after accept; out=0x00, out_hi=0x01, flags=1011.
- DIVU 0x64/0x07 -> out=0x0E, out_hi=0x02, flags=0000.
  - DIVU 0x5A/0x00 -> out=0xFF, out_hi=0x5A, flags=0101.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL result appears; toggle in1/in2/in_valid meanwhile.
  - Required: out, out_hi and flags stable; no new accept.
  - After out_ready=1: state IDLE next cycle.
- Reset mid-MUL: assert rst 3 cycles into BUSY -> next cycle out_valid=0, outputs 0, in_ready=1; a following ADD completes normally with latency 1.
